// File: rtl/entity_slot_scheduler.sv
// entity_slot_scheduler
//   Shares the frame buffer's entity channels between N_REQ requesters.
//   Writes land in shadow slots through a round-robin valid/ready port.
//   On frame_sync the whole shadow is copied to entity_out at one edge.
//   Handshake: a write transfers on a rising edge where req_valid[i] and
//   req_ready[i] are both high. req_ready is combinational, has at most one
//   bit set, and a requester holds valid and payload stable until ready.
//   busy exposes the FSM state (high in COMMIT).
//   Optional: define ENTITY_SCHED_FRAME_COUNT_EN to get an 8-bit commit
//   counter on frame_count; otherwise frame_count is tied to zero.
module entity_slot_scheduler #(
    parameter int              N_REQ     = 4,
    parameter int              N_SLOTS   = 9,
    parameter int              ENT_W     = 14,
    parameter int              SLOT_W    = 4,
    parameter logic [ENT_W-1:0] BLANK_ENT = 14'h3C00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_sync,
    input  logic                       clear_all,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*SLOT_W-1:0]    req_slot,
    input  logic [N_REQ*ENT_W-1:0]     req_entity,
    output logic [N_SLOTS*ENT_W-1:0]   entity_out,
    output logic                       commit_pulse,
    output logic                       busy,
    output logic                       bad_slot_err,
    output logic [7:0]                 frame_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [ENT_W-1:0] shadow_q [N_SLOTS];
    logic [ENT_W-1:0] shadow_d [N_SLOTS];
    logic [ENT_W-1:0] live_q   [N_SLOTS];
    logic [ENT_W-1:0] live_d   [N_SLOTS];
    logic             commit_q, commit_d;
    logic             bad_q, bad_d;

    logic             found;
    logic             xfer;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] grant_idx;
    logic [SLOT_W-1:0] wr_slot;
    logic [ENT_W-1:0] wr_ent;
    logic             wr_in_range;

    // Round-robin search from the pointer; clear_all, COMMIT and reset block all grants
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        xfer      = found && (state_q == ST_ACCEPT) && !clear_all && !reset;
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
        wr_slot     = req_slot[grant_idx*SLOT_W +: SLOT_W];
        wr_ent      = req_entity[grant_idx*ENT_W +: ENT_W];
        wr_in_range = (wr_slot < SLOT_W'(N_SLOTS));
    end

    // Next-state: shadow writes/clears in ACCEPT, one-edge copy to live in COMMIT
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        commit_d = 1'b0;
        bad_d    = bad_q;
        if (state_q == ST_ACCEPT) begin
            if (clear_all) begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    shadow_d[k] = BLANK_ENT;
                end
            end else if (xfer) begin
                // Out-of-range slots still complete the handshake; data is dropped
                for (int k = 0; k < N_SLOTS; k++) begin
                    if (wr_in_range && (wr_slot == SLOT_W'(k))) begin
                        shadow_d[k] = wr_ent;
                    end
                end
                if (!wr_in_range) begin
                    bad_d = 1'b1;
                end
                rr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (frame_sync) begin
                state_d = ST_COMMIT;
            end
        end else begin
            // frame_sync and clear_all are ignored here, not queued
            live_d   = shadow_q;
            commit_d = 1'b1;
            state_d  = ST_ACCEPT;
        end
    end

    // State registers with asynchronous reset to a blank scene
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ACCEPT;
            rr_q     <= '0;
            commit_q <= 1'b0;
            bad_q    <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                shadow_q[k] <= BLANK_ENT;
                live_q[k]   <= BLANK_ENT;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            commit_q <= commit_d;
            bad_q    <= bad_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_out
        assign entity_out[g*ENT_W +: ENT_W] = live_q[g];
    end

    assign busy         = (state_q == ST_COMMIT);
    assign commit_pulse = commit_q;
    assign bad_slot_err = bad_q;

`ifdef ENTITY_SCHED_FRAME_COUNT_EN
    logic [7:0] fc_q, fc_d;

    // Count commit edges, wrapping naturally at 8 bits
    always_comb begin
        fc_d = fc_q;
        if (state_q == ST_COMMIT) begin
            fc_d = fc_q + 8'd1;
        end
    end

    // Commit counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q <= 8'h00;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_count = fc_q;
`else
    assign frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Bench for entity_slot_scheduler: directed scenarios followed by random
// requester traffic, all checked against a scene-level reference model.
module tb_entity_slot_scheduler;

  localparam int N_REQ   = 4;
  localparam int N_SLOTS = 9;
  localparam int ENT_W   = 14;
  localparam int SLOT_W  = 4;
  localparam logic [ENT_W-1:0] BLANK = 14'h3C00;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     frame_sync;
  logic                     clear_all;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*SLOT_W-1:0]  req_slot;
  logic [N_REQ*ENT_W-1:0]   req_entity;
  logic [N_SLOTS*ENT_W-1:0] entity_out;
  logic                     commit_pulse;
  logic                     busy;
  logic                     bad_slot_err;
  logic [7:0]               frame_count;

  int errors = 0;
  int checks = 0;

  // reference model: the scene as the game logic sees it
  logic [ENT_W-1:0] sh_m   [N_SLOTS];
  logic [ENT_W-1:0] live_m [N_SLOTS];
  int               rr_m;
  bit               busy_m;
  bit               commit_m;
  bit               bad_m;
  logic [7:0]       fc_m;
  int               last_g;

  entity_slot_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_sync   (frame_sync),
    .clear_all    (clear_all),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_slot     (req_slot),
    .req_entity   (req_entity),
    .entity_out   (entity_out),
    .commit_pulse (commit_pulse),
    .busy         (busy),
    .bad_slot_err (bad_slot_err),
    .frame_count  (frame_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N_SLOTS; k++) begin
      sh_m[k]   = BLANK;
      live_m[k] = BLANK;
    end
    rr_m     = 0;
    busy_m   = 1'b0;
    commit_m = 1'b0;
    bad_m    = 1'b0;
    fc_m     = 8'h00;
    last_g   = -1;
  endfunction

  // which requester the round-robin rule picks right now (-1: none)
  function automatic int exp_grant(input logic [N_REQ-1:0] v, input bit ca);
    logic [1:0] j;
    if (busy_m || ca) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      j = 2'((rr_m + k) % N_REQ);
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  // scene update at a clock edge given the requester picked before it
  function automatic void model_edge(input int g);
    int slot;
    if (busy_m) begin
      for (int k = 0; k < N_SLOTS; k++) live_m[k] = sh_m[k];
      fc_m     = fc_m + 8'd1;
      busy_m   = 1'b0;
      commit_m = 1'b1;
    end else begin
      commit_m = 1'b0;
      if (clear_all) begin
        for (int k = 0; k < N_SLOTS; k++) sh_m[k] = BLANK;
      end else if (g >= 0) begin
        slot = int'(req_slot[g*SLOT_W +: SLOT_W]);
        if (slot < N_SLOTS) sh_m[slot] = req_entity[g*ENT_W +: ENT_W];
        else bad_m = 1'b1;
        rr_m = (g + 1) % N_REQ;
      end
      if (frame_sync) busy_m = 1'b1;
    end
  endfunction

  function automatic logic [7:0] exp_fc();
`ifdef ENTITY_SCHED_FRAME_COUNT_EN
    return fc_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    logic [N_SLOTS*ENT_W-1:0] flat;
    for (int k = 0; k < N_SLOTS; k++) flat[k*ENT_W +: ENT_W] = live_m[k];
    check({tag, ".entity_out"}, entity_out, flat);
    check({tag, ".commit_pulse"}, commit_pulse, commit_m);
    check({tag, ".busy"}, busy, busy_m);
    check({tag, ".bad_slot_err"}, bad_slot_err, bad_m);
    check({tag, ".frame_count"}, frame_count, exp_fc());
  endtask

  // driver: set one requester's port
  task automatic set_req(input logic [1:0] i, input bit v, input logic [3:0] s, input logic [13:0] e);
    req_valid[i] = v;
    req_slot[int'(i)*SLOT_W +: SLOT_W] = s;
    req_entity[int'(i)*ENT_W +: ENT_W] = e;
  endtask

  // one clock with inputs already driven: check ready, step, check registers
  task automatic cycle(input string tag);
    int g;
    logic [N_REQ-1:0] exp_rdy;
    #1;
    g = exp_grant(req_valid, clear_all);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[2'(g)] = 1'b1;
    check({tag, ".req_ready"}, req_ready, exp_rdy);
    @(posedge clk);
    model_edge(g);
    last_g = g;
    #1;
    check_outputs(tag);
  endtask

  int n_commits;
  bit pend [N_REQ];
  logic [3:0] rs [N_REQ];
  logic [13:0] re [N_REQ];

  initial begin
    // reset with every requester already asserting valid
    reset = 1'b1; frame_sync = 1'b0; clear_all = 1'b0;
    req_valid = '0; req_slot = '0; req_entity = '0;
    for (int i = 0; i < N_REQ; i++) set_req(2'(i), 1'b1, 4'(i), 14'h0100 + 14'(i));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_ready", req_ready, 4'b0000);
    check_outputs("reset");
    reset = 1'b0;

    // round robin with all valid: 0,1,2,3,0,1,2,3
    for (int n = 0; n < 8; n++) begin
      #1;
      check("rr.order", req_ready, 4'b0001 << (n % 4));
      cycle("rr");
    end
    // only req2 valid after req3 was granted
    req_valid = 4'b0100;
    #1;
    check("rr.only2", req_ready, 4'b0100);
    cycle("rr2");

    // shadowing: write not visible until commit
    req_valid = '0;
    set_req(2'd0, 1'b1, 4'd2, 14'h0A55);
    cycle("shadow.wr");
    req_valid = '0;
    repeat (3) cycle("shadow.idle");
    check("shadow.hidden", entity_out[2*ENT_W +: ENT_W], BLANK);
    frame_sync = 1'b1;
    cycle("shadow.t");
    frame_sync = 1'b0;
    check("shadow.busy_t1", busy, 1'b1);
    check("shadow.no_update_t1", entity_out[2*ENT_W +: ENT_W], BLANK);
    cycle("shadow.t1");
    check("shadow.slot2_t2", entity_out[2*ENT_W +: ENT_W], 14'h0A55);
    check("shadow.pulse_t2", commit_pulse, 1'b1);
    cycle("shadow.t3");

    // collision: frame_sync + write + clear_all -> blank scene committed
    set_req(2'd1, 1'b1, 4'd8, 14'h1FF0);
    frame_sync = 1'b1; clear_all = 1'b1;
    #1;
    check("coll.ready_clear", req_ready, 4'b0000);
    cycle("coll.clr");
    frame_sync = 1'b0; clear_all = 1'b0; req_valid = '0;
    cycle("coll.clr_busy");
    check("coll.all_blank", entity_out, {N_SLOTS{BLANK}});
    // same without clear_all: the write is committed
    set_req(2'd1, 1'b1, 4'd8, 14'h1FF0);
    frame_sync = 1'b1;
    cycle("coll.wr");
    frame_sync = 1'b0; req_valid = '0;
    cycle("coll.wr_busy");
    check("coll.slot8", entity_out[8*ENT_W +: ENT_W], 14'h1FF0);

    // bad slot: handshake completes, data dropped, sticky error
    set_req(2'd3, 1'b1, 4'd12, 14'h2222);
    #1;
    check("bad.ready", req_ready, 4'b1000);
    cycle("bad.wr");
    req_valid = '0;
    check("bad.err", bad_slot_err, 1'b1);
    frame_sync = 1'b1;
    cycle("bad.fs");
    frame_sync = 1'b0;
    cycle("bad.commit");
    check("bad.err_sticky", bad_slot_err, 1'b1);

    // COMMIT blocking: two consecutive frame_sync -> one commit, no grants while busy
    n_commits = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_req(2'(i), 1'b1, 4'(4 + i), 14'h0200 + 14'(i));
    frame_sync = 1'b1;
    cycle("blk.fs1");
    req_valid = 4'b1111;
    #1;
    check("blk.ready_busy", req_ready, 4'b0000);
    cycle("blk.fs2");
    frame_sync = 1'b0; req_valid = '0;
    if (commit_pulse === 1'b1) n_commits++;
    for (int n = 0; n < 4; n++) begin
      cycle("blk.idle");
      if (commit_pulse === 1'b1) n_commits++;
    end
    check("blk.one_commit", n_commits, 1);

    // random traffic from well-behaved requesters
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    req_valid = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i == last_g) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(2, 0) == 0) begin
          pend[i] = 1'b1;
          rs[i] = ($urandom_range(15, 0) == 0) ? 4'(10 + $urandom_range(5, 0)) : 4'($urandom_range(8, 0));
          re[i] = 14'($urandom);
        end
        set_req(2'(i), pend[i], rs[i], re[i]);
      end
      frame_sync = ($urandom_range(7, 0) == 0);
      clear_all  = ($urandom_range(19, 0) == 0);
      cycle("rand");
    end
    frame_sync = 1'b0; clear_all = 1'b0; req_valid = '0;

    // async reset in the middle of COMMIT
    set_req(2'd0, 1'b1, 4'd0, 14'h0123);
    frame_sync = 1'b1;
    cycle("rst.fs");
    frame_sync = 1'b0;
    cycle("rst.commit");
    set_req(2'd0, 1'b1, 4'd1, 14'h0456);
    frame_sync = 1'b1;
    cycle("rst.fs2");
    frame_sync = 1'b0;
    req_valid = 4'b1111;
    check("rst.pre_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst.entity_out", entity_out, {N_SLOTS{BLANK}});
    check("rst.busy", busy, 1'b0);
    check("rst.req_ready", req_ready, 4'b0000);
    check("rst.bad_slot_err", bad_slot_err, 1'b0);
    check("rst.commit_pulse", commit_pulse, 1'b0);
    check("rst.frame_count", frame_count, 8'h00);
    @(posedge clk);
    #1;
    check_outputs("rst.hold");
    reset = 1'b0;
    req_valid = '0;

    // frame counter wrap: 256 commits
    for (int n = 0; n < 256; n++) begin
      frame_sync = 1'b1;
      cycle("wrap.fs");
      frame_sync = 1'b0;
      cycle("wrap.commit");
      if (n == 254) begin
`ifdef ENTITY_SCHED_FRAME_COUNT_EN
        check("wrap.at_255", frame_count, 8'hFF);
`else
        check("wrap.at_255", frame_count, 8'h00);
`endif
      end
    end
    check("wrap.zero", frame_count, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
